leaf_stream_adapter: RTL and testbench
======================================

Name: leaf_stream_adapter

Overview:
- Parametrised glue between the user side of a leaf_interface and an HLS operator.
- Generalises the fixed 1-in/1-out, 32-bit direct hookup to N input and M output channels.
- Input channels pack RATIO interface words into one operator beat; output channels unpack each operator beat into RATIO words.
- Adds a run-control FSM for operator ap_start/ap_done and a flush mechanism for partially packed beats.

Parameters:
NUM_IN_PORTS, 1, number of interface→operator channels (1..8)
NUM_OUT_PORTS, 1, number of operator→interface channels (1..8)
PAYLOAD_BITS, 32, interface word width
RATIO, 2, interface words per operator beat (1..8); operator width OP_BITS = RATIO*PAYLOAD_BITS
AUTO_RESTART, 1, 1 = keep operator started after ap_done; 0 = return to idle

Ports:
clk  in  1  single clock
ap_rst_n  in  1  asynchronous active-low reset
start  in  1  level; launches operator run from IDLE
flush  in  1  level; emit partially packed input beats, zero-padded
dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  words from leaf_interface, channel i at slice i
vld_interface2user  in  NUM_IN_PORTS  word valid per channel
ack_user2interface  out  NUM_IN_PORTS  word accepted per channel
din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  words to leaf_interface
vld_user2interface  out  NUM_OUT_PORTS  word valid per channel
ack_interface2user  in  NUM_OUT_PORTS  leaf_interface accepts word
op_in_tdata  out  NUM_IN_PORTS*OP_BITS  packed beats to operator
op_in_tvalid  out  NUM_IN_PORTS  beat valid
op_in_tready  in  NUM_IN_PORTS  operator accepts beat
op_out_tdata  in  NUM_OUT_PORTS*OP_BITS  beats from operator
op_out_tvalid  in  NUM_OUT_PORTS  beat valid
op_out_tready  out  NUM_OUT_PORTS  adapter accepts beat
op_ap_start  out  1  operator ap_start
op_ap_done  in  1  operator ap_done pulse
running  out  1  FSM in RUN

Behaviour:
- Reset (async assert, sync release): all valid outputs 0, op_ap_start 0, running 0, pack counts 0, unpack indices 0, FSM IDLE. Data registers cleared to 0.
- Handshakes: a transfer occurs on a cycle with valid&ready/ack high. Once raised, valid holds with stable data until the transfer occurs. No combinational path from any ready input to any valid output.
- Pack channel (per input):
  - Registers: lane[RATIO], cnt (0..RATIO-1), beat_valid.
  - ack_user2interface = !beat_valid | op_in_tready (combinational in op_in_tready only).
  - Accepted word is written to lane[cnt], word 0 in LSBs.
  - If cnt==RATIO-1: beat_valid←1 next cycle, cnt←0; else cnt+1.
  - Beat consumed and new word accepted in the same cycle are both honoured; full-rate throughput is 1 word/cycle.
  - Latency: beat visible the cycle after the last word is accepted. RATIO=1 acts as a registered slice.
- Flush (per pack channel): when flush=1, cnt>0, no word accepted this cycle and the beat slot is free or being drained:
  - beat_valid←1; lanes ≥cnt forced to 0; cnt←0.
  - flush with cnt==0 has no effect.
- Unpack channel (per output):
  - Registers: beat, idx, hold_valid.
  - op_out_tready = !hold_valid | (ack_interface2user & idx==RATIO-1).
  - din_leaf_user2interface = beat word[idx]; vld = hold_valid.
  - On ack: idx+1. At RATIO-1: idx←0, and either load the next beat (back-to-back, no bubble) or hold_valid←0.
  - First word appears the cycle after the beat is accepted.
- Control FSM: IDLE→RUN when start=1.
  - RUN drives op_ap_start=1 and running=1.
  - op_ap_done in RUN: AUTO_RESTART=1 stays in RUN; AUTO_RESTART=0 goes to IDLE next cycle (op_ap_start drops).
  - op_ap_done in IDLE is ignored.
  - start and op_ap_done together in RUN: done wins when AUTO_RESTART=0.
- Datapath flows independently of FSM state; gating is the operator's responsibility.
- Reset mid-operation discards all partial beats and held words without emitting them.

Decomposition:
- Shared package leaf_stream_pkg: OP_BITS function, lane slice helper, FSM state enum (IDLE, RUN).
- Sub-modules leaf_pack_ch and leaf_unpack_ch, generated NUM_IN_PORTS/NUM_OUT_PORTS times.
- FSM lives in the top module.

Test Plan:
- RATIO=2, in ch0 words 0x11111111, 0x22222222, op_in_tready=1 → op_in_tdata=0x2222222211111111, valid exactly 1 cycle after 2nd accept.
- op_in_tready=0 with a held beat → third word: ack=0 until tready=1; in the tready cycle the word is accepted, the beat is consumed, and cnt=1 after.
- Single word 0xAAAAAAAA then flush=1 → beat 0x00000000AAAAAAAA; flush with cnt=0 → no beat.
- Out beat 0xDEADBEEF_CAFEF00D with ack toggling 1,0,1 → words 0xCAFEF00D then 0xDEADBEEF. A second beat offered during the last ack is accepted with no bubble.
- AUTO_RESTART=0: start pulse → op_ap_start=1 next cycle; op_ap_done pulse → op_ap_start=0 next cycle. Repeat with AUTO_RESTART=1 → stays 1.
- NUM_IN_PORTS=3 random traffic plus ap_rst_n low mid-packet → all valids 0 immediately (asynchronously); the post-reset stream has no stale lanes.

Source files
------------

// File: rtl/leaf_stream_pkg.sv
// Shared types and width helpers for the leaf_interface <-> HLS operator stream adapter.
// Pulled in by the pack/unpack channels and the top-level run-control FSM.
package leaf_stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    // Operator beat width: RATIO interface words side by side
    function automatic int op_bits(input int ratio, input int payload_bits);
        return ratio * payload_bits;
    endfunction

    function automatic int lane_lo(input int lane, input int lane_bits);
        return lane * lane_bits;
    endfunction

    // Counter/index width that never collapses to zero bits when RATIO is 1
    function automatic int idx_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/leaf_pack_ch.sv
// One interface->operator channel: gathers RATIO words into a beat, word 0 in the LSBs.
// The lane registers double as the output beat, so a beat must drain before refilling starts.
module leaf_pack_ch
    import leaf_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int RATIO        = 2,
    localparam int OP_BITS     = op_bits(RATIO, PAYLOAD_BITS)
) (
    input  logic                    clk,
    input  logic                    ap_rst_n,
    input  logic                    flush,
    input  logic [PAYLOAD_BITS-1:0] word,
    input  logic                    word_vld,
    output logic                    word_ack,
    output logic [OP_BITS-1:0]      beat_data,
    output logic                    beat_valid,
    input  logic                    beat_ready
);

    localparam int CNT_W = idx_bits(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    logic [RATIO-1:0][PAYLOAD_BITS-1:0] lanes;
    logic [CNT_W-1:0]                   cnt;
    logic                               beat_vld_q;
    logic                               accept;
    logic                               consume;
    logic                               last_word;
    logic                               flush_fire;

    assign word_ack   = !beat_vld_q | beat_ready;
    assign accept     = word_vld & word_ack;
    assign consume    = beat_vld_q & beat_ready;
    assign last_word  = (cnt == LAST_CNT);
    // A flush only closes a partial beat on a cycle with no incoming word and a free slot
    assign flush_fire = flush && (cnt != '0) && !accept && (!beat_vld_q || beat_ready);

    assign beat_data  = lanes;
    assign beat_valid = beat_vld_q;

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lanes      <= '0;
            cnt        <= '0;
            beat_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < RATIO; i++) begin
                if (accept && (cnt == CNT_W'(i))) begin
                    lanes[i] <= word;
                end else if (flush_fire && (CNT_W'(i) >= cnt)) begin
                    lanes[i] <= '0;
                end
            end

            if (accept) begin
                cnt <= last_word ? '0 : cnt + 1'b1;
            end else if (flush_fire) begin
                cnt <= '0;
            end

            if ((accept && last_word) || flush_fire) begin
                beat_vld_q <= 1'b1;
            end else if (consume) begin
                beat_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/leaf_unpack_ch.sv
// One operator->interface channel: splits each beat into RATIO words, LSB word first.
// The next beat is taken on the same cycle the last word is acknowledged, so streams run gap-free.
module leaf_unpack_ch
    import leaf_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int RATIO        = 2,
    localparam int OP_BITS     = op_bits(RATIO, PAYLOAD_BITS)
) (
    input  logic                    clk,
    input  logic                    ap_rst_n,
    input  logic [OP_BITS-1:0]      beat_data,
    input  logic                    beat_valid,
    output logic                    beat_ready,
    output logic [PAYLOAD_BITS-1:0] word,
    output logic                    word_vld,
    input  logic                    word_ack
);

    localparam int IDX_W = idx_bits(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [RATIO-1:0][PAYLOAD_BITS-1:0] beat;
    logic [IDX_W-1:0]                   idx;
    logic                               hold_valid;
    logic                               last_word;
    logic                               load;

    assign last_word  = (idx == LAST_IDX);
    assign beat_ready = !hold_valid | (word_ack & last_word);
    assign load       = beat_valid & beat_ready;
    assign word_vld   = hold_valid;

    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) begin
                word = beat[i];
            end
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat       <= '0;
            idx        <= '0;
            hold_valid <= 1'b0;
        end else if (load) begin
            beat       <= beat_data;
            idx        <= '0;
            hold_valid <= 1'b1;
        end else if (hold_valid && word_ack) begin
            if (last_word) begin
                idx        <= '0;
                hold_valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_stream_adapter.sv
// Glue between a leaf_interface user port and an HLS operator: N packing inputs, M unpacking
// outputs and an ap_start/ap_done run controller. Data moves regardless of the run state.
module leaf_stream_adapter
    import leaf_stream_pkg::*;
#(
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int PAYLOAD_BITS  = 32,
    parameter int RATIO         = 2,
    parameter bit AUTO_RESTART  = 1'b1,
    localparam int OP_BITS      = op_bits(RATIO, PAYLOAD_BITS)
) (
    input  logic                                  clk,
    input  logic                                  ap_rst_n,
    input  logic                                  start,
    input  logic                                  flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic [NUM_IN_PORTS*OP_BITS-1:0]       op_in_tdata,
    output logic [NUM_IN_PORTS-1:0]               op_in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]               op_in_tready,
    input  logic [NUM_OUT_PORTS*OP_BITS-1:0]      op_out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]              op_out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]              op_out_tready,
    output logic                                  op_ap_start,
    input  logic                                  op_ap_done,
    output logic                                  running
);

    ctrl_state_t state;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_pack
        leaf_pack_ch #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .RATIO        (RATIO)
        ) u_pack (
            .clk        (clk),
            .ap_rst_n   (ap_rst_n),
            .flush      (flush),
            .word       (dout_leaf_interface2user[lane_lo(i, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .word_vld   (vld_interface2user[i]),
            .word_ack   (ack_user2interface[i]),
            .beat_data  (op_in_tdata[lane_lo(i, OP_BITS) +: OP_BITS]),
            .beat_valid (op_in_tvalid[i]),
            .beat_ready (op_in_tready[i])
        );
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_unpack
        leaf_unpack_ch #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .RATIO        (RATIO)
        ) u_unpack (
            .clk        (clk),
            .ap_rst_n   (ap_rst_n),
            .beat_data  (op_out_tdata[lane_lo(j, OP_BITS) +: OP_BITS]),
            .beat_valid (op_out_tvalid[j]),
            .beat_ready (op_out_tready[j]),
            .word       (din_leaf_user2interface[lane_lo(j, PAYLOAD_BITS) +: PAYLOAD_BITS]),
            .word_vld   (vld_user2interface[j]),
            .word_ack   (ack_interface2user[j])
        );
    end

    // In RUN a done pulse either keeps the operator started or, without auto-restart, drops
    // back to IDLE even if start is still asserted.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            op_ap_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        op_ap_start <= 1'b1;
                        running     <= 1'b1;
                    end
                end
                RUN: begin
                    if (op_ap_done && !AUTO_RESTART) begin
                        state       <= IDLE;
                        op_ap_start <= 1'b0;
                        running     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Directed plus random bench for leaf_stream_adapter: a 3-in/1-out RATIO=2 instance without
// auto-restart, and a minimal auto-restart instance sharing start/done for the run controller.
module tb_leaf_stream_adapter;

    localparam int NI  = 3;
    localparam int W   = 32;
    localparam int OPB = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              ap_rst_n;
    logic              start;
    logic              flush;
    logic              op_ap_done;
    logic [NI*W-1:0]   dout_l;
    logic [NI-1:0]     vld_in;
    logic [NI-1:0]     ack_in;
    logic [NI*OPB-1:0] op_in_tdata;
    logic [NI-1:0]     op_in_tvalid;
    logic [NI-1:0]     op_in_tready;
    logic [W-1:0]      din_l;
    logic              vld_out;
    logic              ack_out;
    logic [OPB-1:0]    op_out_tdata;
    logic              op_out_tvalid;
    logic              op_out_tready;
    logic              ap_start0;
    logic              running0;

    logic              d1_ack_in;
    logic [W-1:0]      d1_din;
    logic              d1_vld_out;
    logic [OPB-1:0]    d1_in_tdata;
    logic              d1_in_tvalid;
    logic              d1_out_tready;
    logic              ap_start1;
    logic              running1;

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [31:0] oq[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] half[NI];
    bit          have_half[NI];
    bit          acc[NI];
    logic [31:0] w;

    leaf_stream_adapter #(
        .NUM_IN_PORTS  (NI),
        .NUM_OUT_PORTS (1),
        .PAYLOAD_BITS  (W),
        .RATIO         (2),
        .AUTO_RESTART  (1'b0)
    ) dut (
        .clk                      (clk),
        .ap_rst_n                 (ap_rst_n),
        .start                    (start),
        .flush                    (flush),
        .dout_leaf_interface2user (dout_l),
        .vld_interface2user       (vld_in),
        .ack_user2interface       (ack_in),
        .din_leaf_user2interface  (din_l),
        .vld_user2interface       (vld_out),
        .ack_interface2user       (ack_out),
        .op_in_tdata              (op_in_tdata),
        .op_in_tvalid             (op_in_tvalid),
        .op_in_tready             (op_in_tready),
        .op_out_tdata             (op_out_tdata),
        .op_out_tvalid            (op_out_tvalid),
        .op_out_tready            (op_out_tready),
        .op_ap_start              (ap_start0),
        .op_ap_done               (op_ap_done),
        .running                  (running0)
    );

    leaf_stream_adapter #(
        .AUTO_RESTART (1'b1)
    ) dut_ar (
        .clk                      (clk),
        .ap_rst_n                 (ap_rst_n),
        .start                    (start),
        .flush                    (1'b0),
        .dout_leaf_interface2user (32'h0),
        .vld_interface2user       (1'b0),
        .ack_user2interface       (d1_ack_in),
        .din_leaf_user2interface  (d1_din),
        .vld_user2interface       (d1_vld_out),
        .ack_interface2user       (1'b0),
        .op_in_tdata              (d1_in_tdata),
        .op_in_tvalid             (d1_in_tvalid),
        .op_in_tready             (1'b0),
        .op_out_tdata             (64'h0),
        .op_out_tvalid            (1'b0),
        .op_out_tready            (d1_out_tready),
        .op_ap_start              (ap_start1),
        .op_ap_done               (op_ap_done),
        .running                  (running1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushIn(input int c, input logic [63:0] beat);
        case (c)
            0:       q0.push_back(beat);
            1:       q1.push_back(beat);
            default: q2.push_back(beat);
        endcase
    endtask

    task automatic popIn(input int c, output logic [63:0] beat);
        beat = 'x;
        case (c)
            0:       if (q0.size() > 0) beat = q0.pop_front();
            1:       if (q1.size() > 0) beat = q1.pop_front();
            default: if (q2.size() > 0) beat = q2.pop_front();
        endcase
    endtask

    // Presents one word on channel c and holds it until the adapter acknowledges it
    task automatic applyStimulus(input int c, input logic [31:0] word);
        int n;
        @(posedge clk); #1;
        dout_l[c*W +: W] = word;
        vld_in[c] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ack_in[c] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack_in[c]) checkOutput("ack_timeout", {63'b0, ack_in[c]}, 64'd1);
        @(posedge clk); #1;
        vld_in[c] = 1'b0;
    endtask

    // Scoreboard side: every completed transfer is compared against the oldest expectation
    always @(negedge clk) begin
        logic [63:0] e_in;
        logic [31:0] e_out;
        if (ap_rst_n === 1'b1) begin
            for (int c = 0; c < NI; c++) begin
                if (op_in_tvalid[c] && op_in_tready[c]) begin
                    popIn(c, e_in);
                    checkOutput($sformatf("in_beat%0d", c), op_in_tdata[c*OPB +: OPB], e_in);
                end
            end
            if (vld_out && ack_out) begin
                e_out = (oq.size() > 0) ? oq.pop_front() : 'x;
                checkOutput("out_word", {32'b0, din_l}, {32'b0, e_out});
            end
        end
    end

    initial begin
        ap_rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_ap_done = 1'b0;
        dout_l = '0; vld_in = '0; op_in_tready = '0;
        ack_out = 1'b0; op_out_tdata = '0; op_out_tvalid = 1'b0;
        for (int c = 0; c < NI; c++) begin
            have_half[c] = 1'b0;
            half[c] = '0;
        end

        #12;
        checkOutput("rst_in_tvalid", {61'b0, op_in_tvalid}, 64'd0);
        checkOutput("rst_vld_out", {63'b0, vld_out}, 64'd0);
        checkOutput("rst_ap_start", {62'b0, ap_start0, ap_start1}, 64'd0);
        checkOutput("rst_running", {63'b0, running0}, 64'd0);
        checkOutput("rst_ack_in", {61'b0, ack_in}, 64'h7);
        checkOutput("rst_out_tready", {63'b0, op_out_tready}, 64'd1);
        @(negedge clk); #1;
        ap_rst_n = 1'b1;

        $display("[TB] pack latency");
        op_in_tready[0] = 1'b1;
        pushIn(0, 64'h22222222_11111111);
        applyStimulus(0, 32'h11111111);
        checkOutput("pack_not_yet", {63'b0, op_in_tvalid[0]}, 64'd0);
        applyStimulus(0, 32'h22222222);
        checkOutput("pack_vld", {63'b0, op_in_tvalid[0]}, 64'd1);
        checkOutput("pack_data", op_in_tdata[63:0], 64'h22222222_11111111);
        @(posedge clk); #1;
        checkOutput("pack_one_cycle", {63'b0, op_in_tvalid[0]}, 64'd0);

        $display("[TB] backpressure");
        op_in_tready[0] = 1'b0;
        pushIn(0, 64'h44444444_33333333);
        applyStimulus(0, 32'h33333333);
        applyStimulus(0, 32'h44444444);
        dout_l[31:0] = 32'h55555555;
        vld_in[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ack_held", {63'b0, ack_in[0]}, 64'd0);
        end
        @(posedge clk); #1;
        op_in_tready[0] = 1'b1;
        @(negedge clk);
        checkOutput("ack_tready", {63'b0, ack_in[0]}, 64'd1);
        @(posedge clk); #1;
        vld_in[0] = 1'b0;
        checkOutput("beat_drained", {63'b0, op_in_tvalid[0]}, 64'd0);
        pushIn(0, 64'h66666666_55555555);
        applyStimulus(0, 32'h66666666);
        checkOutput("beat_after_bp", {63'b0, op_in_tvalid[0]}, 64'd1);

        $display("[TB] flush");
        pushIn(0, 64'h00000000_AAAAAAAA);
        applyStimulus(0, 32'hAAAAAAAA);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_vld", {63'b0, op_in_tvalid[0]}, 64'd1);
        checkOutput("flush_data", op_in_tdata[63:0], 64'h00000000_AAAAAAAA);
        @(posedge clk); #1;
        flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("flush_empty", {63'b0, op_in_tvalid[0]}, 64'd0);
        end
        @(posedge clk); #1;
        flush = 1'b0;

        $display("[TB] unpack");
        op_out_tdata = 64'hDEADBEEF_CAFEF00D;
        op_out_tvalid = 1'b1;
        oq.push_back(32'hCAFEF00D);
        oq.push_back(32'hDEADBEEF);
        @(negedge clk);
        checkOutput("out_tready_idle", {63'b0, op_out_tready}, 64'd1);
        @(posedge clk); #1;
        op_out_tvalid = 1'b0;
        checkOutput("out_first_vld", {63'b0, vld_out}, 64'd1);
        checkOutput("out_first_word", {32'b0, din_l}, 64'hCAFEF00D);
        ack_out = 1'b1;
        @(posedge clk); #1;
        ack_out = 1'b0;
        checkOutput("out_second_word", {32'b0, din_l}, 64'hDEADBEEF);
        @(negedge clk);
        checkOutput("out_tready_hold", {63'b0, op_out_tready}, 64'd0);
        @(posedge clk); #1;
        ack_out = 1'b1;
        op_out_tdata = 64'h12345678_9ABCDEF0;
        op_out_tvalid = 1'b1;
        oq.push_back(32'h9ABCDEF0);
        oq.push_back(32'h12345678);
        @(negedge clk);
        checkOutput("out_tready_last", {63'b0, op_out_tready}, 64'd1);
        @(posedge clk); #1;
        op_out_tvalid = 1'b0;
        checkOutput("out_no_bubble_vld", {63'b0, vld_out}, 64'd1);
        checkOutput("out_no_bubble_word", {32'b0, din_l}, 64'h9ABCDEF0);
        repeat (2) @(posedge clk);
        #1;
        ack_out = 1'b0;
        checkOutput("out_drained", {63'b0, vld_out}, 64'd0);

        $display("[TB] run control");
        op_ap_done = 1'b1;
        @(posedge clk); #1;
        op_ap_done = 1'b0;
        checkOutput("done_in_idle", {62'b0, ap_start0, ap_start1}, 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("start_ar0", {62'b0, ap_start0, running0}, 64'h3);
        checkOutput("start_ar1", {62'b0, ap_start1, running1}, 64'h3);
        op_ap_done = 1'b1;
        @(posedge clk); #1;
        op_ap_done = 1'b0;
        checkOutput("done_ar0", {62'b0, ap_start0, running0}, 64'h0);
        checkOutput("done_ar1", {63'b0, ap_start1}, 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        op_ap_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_ap_done = 1'b0;
        checkOutput("done_beats_start", {63'b0, ap_start0}, 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        $display("[TB] random traffic and mid-packet reset");
        op_out_tdata = 64'h0BAD0BAD_0BAD0BAD;
        op_out_tvalid = 1'b1;
        oq.push_back(32'h0BAD0BAD);
        @(posedge clk); #1;
        op_out_tvalid = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NI; c++) acc[c] = vld_in[c] && ack_in[c];
            @(posedge clk); #1;
            for (int c = 0; c < NI; c++) begin
                op_in_tready[c] = ($urandom_range(0, 3) != 0);
                if (!vld_in[c] || acc[c]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        w = $urandom;
                        dout_l[c*W +: W] = w;
                        vld_in[c] = 1'b1;
                        if (have_half[c]) begin
                            pushIn(c, {w, half[c]});
                            have_half[c] = 1'b0;
                        end else begin
                            half[c] = w;
                            have_half[c] = 1'b1;
                        end
                    end else begin
                        vld_in[c] = 1'b0;
                    end
                end
            end
        end
        checkOutput("pre_reset_vld_out", {63'b0, vld_out}, 64'd1);
        checkOutput("pre_reset_running", {63'b0, running0}, 64'd1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_in_tvalid", {61'b0, op_in_tvalid}, 64'd0);
        checkOutput("async_rst_vld_out", {63'b0, vld_out}, 64'd0);
        checkOutput("async_rst_ap_start", {63'b0, ap_start0}, 64'd0);
        q0.delete(); q1.delete(); q2.delete(); oq.delete();
        vld_in = '0;
        op_in_tready = '0;
        for (int c = 0; c < NI; c++) have_half[c] = 1'b0;
        @(negedge clk); #1;
        ap_rst_n = 1'b1;

        op_in_tready = 3'b111;
        for (int c = 0; c < NI; c++) begin
            for (int k = 0; k < 2; k++) begin
                pushIn(c, {32'hB0B0_0000 + 32'(c*16 + 2*k + 1), 32'hA0A0_0000 + 32'(c*16 + 2*k)});
                applyStimulus(c, 32'hA0A0_0000 + 32'(c*16 + 2*k));
                applyStimulus(c, 32'hB0B0_0000 + 32'(c*16 + 2*k + 1));
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("q0_drained", 64'(q0.size()), 64'd0);
        checkOutput("q1_drained", 64'(q1.size()), 64'd0);
        checkOutput("q2_drained", 64'(q2.size()), 64'd0);
        checkOutput("oq_drained", 64'(oq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
